sonar_scheduler: RTL and testbench
==================================

# sonar_scheduler

Round-robin sequencer for the three ultrasonic sonars on the front sensor bar. It fires one sonar at a time so that no echo is heard by a neighbouring transducer, and measures each echo pulse width in clock cycles. It applies a no-echo and over-range timeout, then publishes per-sonar 20-bit results with a one-cycle valid strobe. It sits between the sonar pins (T1..T3 out, S1..S3 in) and the register/readout logic that consumes R1..R3.

## Interface

- TRIG_CYCLES, 1000: trigger pulse width in cycles (10 us at 100 MHz).
- TIMEOUT_CYCLES, 1000000: limit for both the wait-for-echo phase and the echo-high phase (10 ms). Must be < 2^20.
- GUARD_CYCLES, 200000: dead time after each sonar before the next trigger (2 ms).

- clk  in  1  system clock, 100 MHz nominal.
- reset  in  1  one clock; reset is asynchronous and active-low.
- enable  in  1  run the scan while high.
- mask  in  3  per-sonar enable; bit0 = sonar 1.
- S1, S2, S3  in  1 each  asynchronous echo inputs.
- T1, T2, T3  out  1 each  trigger outputs, registered.
- R1, R2, R3  out  20 each  last echo width in cycles, or 20'hFFFFF on timeout.
- valid  out  3  one-cycle strobe, bit i high on the cycle R(i+1) updates.
- tmo  out  3  sticky-per-result flag: bit i = 1 if the latest R(i+1) is a timeout.
- busy  out  1  high whenever state is not IDLE.
- sel  out  2  index (0..2) of the sonar currently owned; 0 in IDLE.

## Operation

- S1..S3 each pass through a 2-flop synchronizer. All logic uses the synchronized versions (s_sync).
- FSM states and transitions:
  - IDLE: if enable && |mask, pick the first set mask bit from index 0 and go to TRIG. Otherwise stay.
  - TRIG: T(sel) high. After TRIG_CYCLES cycles go to WAIT_RISE.
  - WAIT_RISE: detect a rising edge of s_sync(sel) (previous 0, current 1), then go to MEASURE with count=1. If TIMEOUT_CYCLES elapse first, write a timeout result and go to GUARD.
  - MEASURE: count +1 per cycle while s_sync(sel)=1. On the falling edge, write R=count, tmo=0, and go to GUARD. If count reaches TIMEOUT_CYCLES, write a timeout result and go to GUARD.
  - GUARD: count GUARD_CYCLES. Then go to IDLE if enable=0 or mask=0. Otherwise go to TRIG with sel = next set mask bit strictly after sel, wrapping. If only sel is set, it is reselected.
- Timeout result: R(sel)=20'hFFFFF and tmo(sel)=1.
- Every result write pulses valid(sel) for exactly one cycle.
- Only the selected sonar's echo is observed. Activity on other S inputs is ignored.
- An echo already high when TRIG ends does not count; a fresh rising edge is required. A stuck-high echo therefore times out in WAIT_RISE.
- Counter is 20 bits and saturates at TIMEOUT_CYCLES. It never wraps.
- R and tmo hold their value until the next write for that sonar.
- enable and mask are sampled only in IDLE and at the end of GUARD. Dropping enable mid-cycle completes the current sonar, including GUARD.

## Timing

- Reset values: T1..T3=0, R1..R3=0, valid=0, tmo=0, busy=0, sel=0. FSM in IDLE, synchronizers cleared.
- Asserting reset in any state forces these values asynchronously. T drops immediately with no partial result.
- IDLE→TRIG happens on the first edge that samples enable=1 with mask≠0. T(sel) is high for exactly the TRIG_CYCLES cycles following that edge.
- Echo latency: R update and valid occur 3 cycles after the pin falls (2 synchronizer + 1 register).
- An echo high for E cycles gives R=E±1 (asynchronous alignment).
- Sonar period = TRIG_CYCLES + wait + echo + GUARD_CYCLES + 1 transition cycle per state boundary. There is no extra idle cycle between GUARD and the next TRIG.

## Test plan

- All three sonars, with S1/S2/S3 echoing 2.5/4.5/6.5 ms after each trigger: T fires in order 1,2,3,1. R1≈250000, R2≈450000, R3≈650000 (±2). valid pulses once each per round, tmo=0, T never overlaps.
- mask=3'b101: only T1 and T3 pulse, alternating. T2 stays 0 and R2 stays 0.
- No echo on S2: 1000000 cycles after T2 falls, R2=20'hFFFFF, tmo[1]=1, valid[1] pulses. A later good echo clears tmo[1].
- S1 held high from before the trigger: WAIT_RISE times out, R1=20'hFFFFF. An echo longer than 10 ms also gives 20'hFFFFF.
- enable dropped during MEASURE of sonar 2: R2 is still written, GUARD completes, FSM returns to IDLE. busy falls, no further triggers.
- reset low during MEASURE of sonar 3: T3=0, R1..R3=0, busy=0 immediately. After release with enable=1, scanning restarts at sonar 1.

Source files
------------

// File: rtl/sonar_scheduler.sv
// sonar_scheduler: round-robin trigger/echo sequencer for three sonars.
// Measures echo width in cycles, with no-echo and over-range timeouts.
module sonar_scheduler #(
    parameter int TRIG_CYCLES    = 1000,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int GUARD_CYCLES   = 200000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [2:0]  mask,
    input  logic        S1,
    input  logic        S2,
    input  logic        S3,
    output logic        T1,
    output logic        T2,
    output logic        T3,
    output logic [19:0] R1,
    output logic [19:0] R2,
    output logic [19:0] R3,
    output logic [2:0]  valid,
    output logic [2:0]  tmo,
    output logic        busy,
    output logic [1:0]  sel
);

    localparam logic [19:0] TRIG_LAST  = 20'(TRIG_CYCLES - 1);
    localparam logic [19:0] TMO_LAST   = 20'(TIMEOUT_CYCLES - 1);
    localparam logic [19:0] GUARD_LAST = 20'(GUARD_CYCLES - 1);
    localparam logic [19:0] NO_ECHO    = 20'hFFFFF;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        GUARD
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [19:0]      cnt;
    logic [19:0]      cnt_n;
    logic [1:0]       sel_n;
    logic [2:0]       s_meta;
    logic [2:0]       s_sync;
    logic [2:0]       s_prev;
    logic [2:0]       trig;
    logic [2:0][19:0] res;
    logic             echo;
    logic             echo_prev;
    logic             wr;
    logic             wr_tmo;
    logic [19:0]      wr_val;

    // Next set mask bit strictly after cur, wrapping back to cur itself.
    function automatic logic [1:0] next_sel(input logic [2:0] m,
                                            input logic [1:0] cur);
        logic [1:0] pick;
        logic [1:0] idx;
        pick = cur;
        for (int k = 3; k >= 1; k--) begin
            idx = 2'((32'(cur) + 32'(k)) % 32'd3);
            if (m[idx]) pick = idx;
        end
        return pick;
    endfunction

    assign echo      = s_sync[sel];
    assign echo_prev = s_prev[sel];
    assign busy      = (state != IDLE);
    assign {T3, T2, T1} = trig;
    assign R1 = res[0];
    assign R2 = res[1];
    assign R3 = res[2];

    // Two-flop synchronizers plus one history stage for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_meta <= '0;
            s_sync <= '0;
            s_prev <= '0;
        end else begin
            s_meta <= {S3, S2, S1};
            s_sync <= s_meta;
            s_prev <= s_sync;
        end
    end

    // State, shared phase counter and owned-sonar index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            sel   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            sel   <= sel_n;
        end
    end

    // Sequencing rules and result-write requests.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sel_n   = sel;
        wr      = 1'b0;
        wr_tmo  = 1'b0;
        wr_val  = cnt;
        unique case (state)
            IDLE: begin
                if (enable && |mask) begin
                    state_n = TRIG;
                    sel_n   = next_sel(mask, 2'd2);
                    cnt_n   = '0;
                end
            end
            TRIG: begin
                if (cnt == TRIG_LAST) begin
                    state_n = WAIT_RISE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 20'd1;
                end
            end
            WAIT_RISE: begin
                if (echo && !echo_prev) begin
                    state_n = MEASURE;
                    cnt_n   = 20'd1;
                end else if (cnt == TMO_LAST) begin
                    wr      = 1'b1;
                    wr_tmo  = 1'b1;
                    state_n = GUARD;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 20'd1;
                end
            end
            MEASURE: begin
                if (!echo) begin
                    wr      = 1'b1;
                    state_n = GUARD;
                    cnt_n   = '0;
                end else if (cnt >= TMO_LAST) begin
                    wr      = 1'b1;
                    wr_tmo  = 1'b1;
                    state_n = GUARD;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 20'd1;
                end
            end
            GUARD: begin
                if (cnt == GUARD_LAST) begin
                    cnt_n = '0;
                    if (enable && |mask) begin
                        state_n = TRIG;
                        sel_n   = next_sel(mask, sel);
                    end else begin
                        state_n = IDLE;
                        sel_n   = 2'd0;
                    end
                end else begin
                    cnt_n = cnt + 20'd1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                sel_n   = 2'd0;
            end
        endcase
    end

    // Registered triggers, results, timeout flags and valid strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trig  <= '0;
            res   <= '0;
            tmo   <= '0;
            valid <= '0;
        end else begin
            trig  <= (state_n == TRIG) ? (3'b001 << sel_n) : 3'b000;
            valid <= wr ? (3'b001 << sel) : 3'b000;
            if (wr) begin
                res[sel] <= wr_tmo ? NO_ECHO : wr_val;
                tmo[sel] <= wr_tmo;
            end
        end
    end

endmodule

// File: tb/tb_sonar_scheduler.sv
// tb_sonar_scheduler: directed scenarios against a timeline model
// of the sonar scan (session start, trigger window, result write, guard end).
module tb_sonar_scheduler;

    localparam int TRIG = 10;
    localparam int TMO  = 300;
    localparam int GRD  = 40;
    localparam int K_NONE  = 0;
    localparam int K_ECHO  = 1;
    localparam int K_STUCK = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [2:0]  mask;
    logic        s1, s2, s3;
    logic        t1, t2, t3;
    logic [19:0] r1, r2, r3;
    logic [2:0]  valid, tmo;
    logic        busy;
    logic [1:0]  sel;
    logic [2:0]  tv;

    int errors = 0;
    int checks = 0;
    int n = 0;
    bit chk_en = 1'b0;
    bit noise = 1'b0;

    int kind [3];
    int dly  [3];
    int wid  [3];

    logic        m_busy;
    logic [1:0]  m_sel;
    int          c0, tf, tw, tend;
    logic [19:0] m_val;
    logic        m_to;

    logic [2:0]  exp_t, exp_valid, exp_tmo;
    logic [19:0] exp_r [3];
    logic        exp_busy;
    logic [1:0]  exp_sel;

    int t2_fall = 0;
    logic t2_prev = 1'b0;

    assign tv = {t3, t2, t1};

    always #5 clk = ~clk;

    sonar_scheduler #(
        .TRIG_CYCLES(TRIG),
        .TIMEOUT_CYCLES(TMO),
        .GUARD_CYCLES(GRD)
    ) dut (
        .clk(clk),
        .reset(rst_n),
        .enable(enable),
        .mask(mask),
        .S1(s1),
        .S2(s2),
        .S3(s3),
        .T1(t1),
        .T2(t2),
        .T3(t3),
        .R1(r1),
        .R2(r2),
        .R3(r3),
        .valid(valid),
        .tmo(tmo),
        .busy(busy),
        .sel(sel)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h (cycle %0d)",
                     nm, act, req, n);
        end
    endtask

    function automatic logic [1:0] first_after(input logic [2:0] mk,
                                               input int s);
        for (int k = 1; k <= 3; k++)
            if (mk[(s + k) % 3]) return 2'((s + k) % 3);
        return 2'd0;
    endfunction

    task automatic model_reset();
        m_busy    = 1'b0;
        m_sel     = 2'd0;
        exp_t     = '0;
        exp_valid = '0;
        exp_tmo   = '0;
        exp_busy  = 1'b0;
        exp_sel   = 2'd0;
        for (int i = 0; i < 3; i++) exp_r[i] = '0;
    endtask

    // One sonar session: every edge of it follows from the start edge.
    task automatic start_session(input logic [1:0] s, input int at);
        int i;
        i      = int'(s);
        m_busy = 1'b1;
        m_sel  = s;
        c0     = at;
        tf     = at + TRIG;
        m_to   = 1'b1;
        m_val  = 20'hFFFFF;
        tw     = tf + TMO;
        if (kind[i] == K_ECHO && dly[i] + 3 <= TMO) begin
            if (wid[i] < TMO) begin
                tw    = tf + dly[i] + wid[i] + 3;
                m_val = 20'(wid[i]);
                m_to  = 1'b0;
            end else begin
                tw = tf + dly[i] + TMO + 2;
            end
        end
        tend = tw + GRD;
    endtask

    task automatic model_edge(input logic en, input logic [2:0] mk,
                              input logic rs);
        exp_valid = '0;
        if (!rs) begin
            model_reset();
            return;
        end
        if (!m_busy) begin
            if (en && |mk) start_session(first_after(mk, 2), n);
        end else if (n == tw) begin
            exp_r[m_sel]     = m_to ? 20'hFFFFF : m_val;
            exp_tmo[m_sel]   = m_to;
            exp_valid[m_sel] = 1'b1;
        end else if (n == tend) begin
            if (en && |mk) begin
                start_session(first_after(mk, int'(m_sel)), n);
            end else begin
                m_busy = 1'b0;
                m_sel  = 2'd0;
            end
        end
        exp_t    = (m_busy && n < tf) ? (3'b001 << m_sel) : 3'b000;
        exp_busy = m_busy;
        exp_sel  = m_sel;
    endtask

    task automatic drive_pins();
        logic [2:0] p;
        for (int i = 0; i < 3; i++) begin
            p[i] = (kind[i] == K_STUCK);
            if (m_busy && int'(m_sel) == i) begin
                if (kind[i] == K_ECHO && n >= tf + dly[i] &&
                    n < tf + dly[i] + wid[i]) p[i] = 1'b1;
            end else if (noise && kind[i] == K_ECHO) begin
                p[i] = n[1];
            end
        end
        s1 = p[0];
        s2 = p[1];
        s3 = p[2];
    endtask

    task automatic step();
        logic       en_s;
        logic [2:0] mk_s;
        logic       rs_s;
        en_s = enable;
        mk_s = mask;
        rs_s = rst_n;
        @(posedge clk);
        #1;
        n++;
        model_edge(en_s, mk_s, rs_s);
        drive_pins();
    endtask

    task automatic wait_valid(input int i, input int budget);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (!valid[i] && k < budget);
        chk($sformatf("wait_valid%0d", i), 32'(valid[i]), 32'd1);
    endtask

    task automatic wait_t(input int i, input int budget);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (!tv[i] && k < budget);
        chk($sformatf("wait_T%0d", i + 1), 32'(tv[i]), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (3) step();
        rst_n = 1'b1;
    endtask

    // Per-cycle comparison of every output against the timeline model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("T", 32'(tv), 32'(exp_t));
            chk("T_overlap", 32'($countones(tv) <= 1), 32'd1);
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("sel", 32'(sel), 32'(exp_sel));
            chk("valid", 32'(valid), 32'(exp_valid));
            chk("tmo", 32'(tmo), 32'(exp_tmo));
            chk("R1", 32'(r1), 32'(exp_r[0]));
            chk("R2", 32'(r2), 32'(exp_r[1]));
            chk("R3", 32'(r3), 32'(exp_r[2]));
            if (t2_prev && !t2) t2_fall = n;
            t2_prev = t2;
        end
    end

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        mask   = 3'b000;
        s1 = 1'b0;
        s2 = 1'b0;
        s3 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            kind[i] = K_ECHO;
            dly[i]  = 5;
        end
        wid[0] = 25;
        wid[1] = 45;
        wid[2] = 65;
        model_reset();
        repeat (3) step();
        chk("rst_T", 32'(tv), 32'd0);
        chk("rst_R", 32'(r1 | r2 | r3), 32'd0);
        chk("rst_busy_sel", 32'({busy, sel, valid, tmo}), 32'd0);
        chk_en = 1'b1;
        rst_n  = 1'b1;
        repeat (5) step();
        chk("idle_busy", 32'(busy), 32'd0);

        // All three sonars, with neighbours chattering.
        noise  = 1'b1;
        mask   = 3'b111;
        enable = 1'b1;
        wait_valid(0, 2000);
        chk("A_R1", 32'(r1), 32'd25);
        wait_valid(1, 2000);
        chk("A_R2", 32'(r2), 32'd45);
        wait_valid(2, 2000);
        chk("A_R3", 32'(r3), 32'd65);
        chk("A_tmo", 32'(tmo), 32'd0);
        wait_valid(0, 2000);

        // Sonars 1 and 3 only.
        enable = 1'b0;
        do_reset();
        mask   = 3'b101;
        enable = 1'b1;
        wait_valid(0, 2000);
        wait_valid(2, 2000);
        wait_valid(0, 2000);
        chk("B_R2", 32'(r2), 32'd0);
        chk("B_R3", 32'(r3), 32'd65);

        // No echo on sonar 2, then a good echo.
        mask    = 3'b111;
        kind[1] = K_NONE;
        wait_valid(1, 3000);
        chk("C_R2_to", 32'(r2), 32'hFFFFF);
        chk("C_tmo", 32'(tmo[1]), 32'd1);
        chk("C_latency", 32'(n - t2_fall), 32'(TMO));
        kind[1] = K_ECHO;
        wait_valid(1, 3000);
        chk("C_R2_ok", 32'(r2), 32'd45);
        chk("C_tmo_clr", 32'(tmo[1]), 32'd0);

        // Stuck-high echo, then an over-range echo on sonar 1.
        kind[0] = K_STUCK;
        wait_valid(0, 3000);
        chk("D_stuck_R1", 32'(r1), 32'hFFFFF);
        chk("D_stuck_tmo", 32'(tmo[0]), 32'd1);
        kind[0] = K_ECHO;
        wid[0]  = 400;
        wait_valid(0, 3000);
        chk("D_long_R1", 32'(r1), 32'hFFFFF);
        chk("D_long_tmo", 32'(tmo[0]), 32'd1);
        wid[0] = 25;

        // Enable dropped while sonar 2 measures.
        wait_t(1, 3000);
        repeat (TRIG + 5 + 3 + 10) step();
        enable = 1'b0;
        wait_valid(1, 1000);
        chk("E_R2", 32'(r2), 32'd45);
        repeat (GRD + 2) step();
        chk("E_busy", 32'(busy), 32'd0);
        repeat (100) step();

        // Reset while sonar 3 measures.
        enable = 1'b1;
        wait_t(2, 3000);
        repeat (TRIG + 5 + 3 + 10) step();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("F_T", 32'(tv), 32'd0);
        chk("F_R", 32'({r1, r2, r3} != 60'd0), 32'd0);
        chk("F_busy", 32'(busy), 32'd0);
        repeat (3) step();
        rst_n = 1'b1;
        wait_t(0, 50);
        chk("F_restart_T", 32'(tv), 32'b001);
        wait_valid(0, 2000);
        chk("F_R1", 32'(r1), 32'd25);
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
